// File: rtl/hold_readout_pkg.sv
// Shared types and width helpers for the hold_readout buffer.
// Optional zero-latency bypass is enabled with the HOLD_READOUT_BYPASS_EN macro.
package hold_readout_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'b00,
        PARTIAL = 2'b01,
        FULL    = 2'b10
    } state_e;

    // Pointer width for a buffer of d words; count needs one extra bit to reach d.
    function automatic int ptr_w(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

endpackage

// File: rtl/hold_readout_mem.sv
// Word storage for hold_readout: one synchronous write port, one asynchronous read port.
module hold_readout_mem
    import hold_readout_pkg::*;
#(
    parameter int word_size = 32,
    parameter int depth     = 4
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [ptr_w(depth)-1:0]   waddr,
    input  logic [word_size-1:0]      wdata,
    input  logic [ptr_w(depth)-1:0]   raddr,
    output logic [word_size-1:0]      rdata
);

    logic [word_size-1:0] mem [depth];

    // NOTE: storage has no reset; validity is tracked by the pointers and state, so
    // resetting the array would only add reset fanout.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/hold_readout.sv
// First-word-fall-through read buffer with valid/ready output, occupancy and sticky overflow.
// Define HOLD_READOUT_BYPASS_EN to let a write into an empty buffer reach the consumer the same cycle.
module hold_readout
    import hold_readout_pkg::*;
#(
    parameter int word_size = 32,
    parameter int depth     = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [word_size-1:0]        input_data,
    input  logic                        write,
    input  logic                        clear,
    output logic [word_size-1:0]        output_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [$clog2(depth):0]      count,
    output logic                        full,
    output logic                        empty,
    output logic                        overflow
);

    localparam int AW = ptr_w(depth);
    localparam int CW = $clog2(depth) + 1;

    state_e                 state_q, state_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   overflow_q, overflow_d;
    logic [word_size-1:0]   last_q, last_d;

    logic [word_size-1:0]   mem_rdata;
    logic                   head_valid;
    logic                   pop;
    logic                   push;
    logic                   bypass;

    hold_readout_mem #(
        .word_size (word_size),
        .depth     (depth)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr_q),
        .wdata (input_data),
        .raddr (rd_ptr_q),
        .rdata (mem_rdata)
    );

    assign head_valid = (state_q != EMPTY);

`ifdef HOLD_READOUT_BYPASS_EN
    assign bypass = (state_q == EMPTY) && write && out_ready && !clear;
`else
    assign bypass = 1'b0;
`endif

    // A full buffer still accepts a write when the head leaves in the same cycle.
    assign pop  = head_valid && out_ready && !clear;
    assign push = write && !clear && !bypass && ((state_q != FULL) || pop);

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (clear) begin
            state_d    = EMPTY;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);

            if (write && (state_q == FULL) && !pop) begin
                overflow_d = 1'b1;
            end

            unique case (state_q)
                EMPTY: begin
                    if (push) state_d = PARTIAL;
                end
                PARTIAL: begin
                    if (pop && !push && (count_q == CW'(1))) begin
                        state_d = EMPTY;
                    end else if (push && !pop && (count_q == CW'(depth - 1))) begin
                        state_d = FULL;
                    end
                end
                FULL: begin
                    if (pop && !push) state_d = PARTIAL;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_comb begin
        out_valid   = head_valid || bypass;
        output_data = last_q;
        if (bypass) begin
            output_data = input_data;
        end else if (head_valid) begin
            output_data = mem_rdata;
        end
        // Remember the last word shown so output_data holds once the buffer drains.
        last_d = out_valid ? output_data : last_q;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= EMPTY;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            last_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            last_q     <= last_d;
        end
    end

    assign count    = count_q;
    assign full     = (state_q == FULL);
    assign empty    = (state_q == EMPTY);
    assign overflow = overflow_q;

endmodule

// File: tb/tb_hold_readout.sv
// Directed self-checking bench for hold_readout (depth 4, 32-bit words).
module tb_hold_readout;

    localparam int WS = 32;
    localparam int DP = 4;

    logic            clk;
    logic            reset_n;
    logic [WS-1:0]   input_data;
    logic            write;
    logic            clear;
    logic [WS-1:0]   output_data;
    logic            out_valid;
    logic            out_ready;
    logic [2:0]      count;
    logic            full;
    logic            empty;
    logic            overflow;

    int checks   = 0;
    int failures = 0;

    hold_readout #(
        .word_size (WS),
        .depth     (DP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .input_data  (input_data),
        .write       (write),
        .clear       (clear),
        .output_data (output_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
    task automatic cyc(input logic w, input logic [WS-1:0] d, input logic rdy, input logic clr);
        write      = w;
        input_data = d;
        out_ready  = rdy;
        clear      = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        write      = 1'b0;
        input_data = '0;
        out_ready  = 1'b0;
        clear      = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        write      = 1'b0;
        input_data = '0;
        out_ready  = 1'b0;
        clear      = 1'b0;
        #2;
        check("rst_count", 64'(count), 64'd0);
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_data", 64'(output_data), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single write, one-cycle latency
        cyc(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
        idle_inputs();
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_data", 64'(output_data), 64'hA5A5_0001);
        check("t1_count", 64'(count), 64'd1);
        check("t1_empty", 64'(empty), 64'd0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("t1_drain_empty", 64'(empty), 64'd1);
        check("t1_drain_valid", 64'(out_valid), 64'd0);

        // Fill, overflow, ordered drain, sticky overflow until clear
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h10 + 32'(i), 1'b0, 1'b0);
        check("t2_full", 64'(full), 64'd1);
        check("t2_count4", 64'(count), 64'd4);
        check("t2_ovf_before", 64'(overflow), 64'd0);
        cyc(1'b1, 32'h14, 1'b0, 1'b0);
        check("t2_ovf", 64'(overflow), 64'd1);
        check("t2_count_ovf", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            check("t2_drain_data", 64'(output_data), 64'h10 + 64'(i));
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
        check("t2_drained_empty", 64'(empty), 64'd1);
        check("t2_ovf_sticky", 64'(overflow), 64'd1);
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("t2_ready_when_empty", 64'(count), 64'd0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        check("t2_ovf_cleared", 64'(overflow), 64'd0);

        // Full buffer: write and pop together
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h30 + 32'(i), 1'b0, 1'b0);
        cyc(1'b1, 32'h20, 1'b1, 1'b0);
        idle_inputs();
        check("t3_count", 64'(count), 64'd4);
        check("t3_full", 64'(full), 64'd1);
        check("t3_ovf", 64'(overflow), 64'd0);
        for (int i = 0; i < 4; i++) begin
            idle_inputs();
            check("t3_drain_data", 64'(output_data), (i == 3) ? 64'h20 : 64'h31 + 64'(i));
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
        check("t3_drained", 64'(empty), 64'd1);

        // Streaming with out_ready held high
        for (int k = 0; k < 10; k++) begin
            write      = 1'b1;
            input_data = 32'h40 + 32'(k);
            out_ready  = 1'b1;
            clear      = 1'b0;
            #1;
`ifdef HOLD_READOUT_BYPASS_EN
            check("t4_byp_valid", 64'(out_valid), 64'd1);
            check("t4_byp_data", 64'(output_data), 64'h40 + 64'(k));
`else
            if (k > 0) check("t4_stream_data", 64'(output_data), 64'h40 + 64'(k) - 64'd1);
`endif
            @(posedge clk);
            #1;
`ifdef HOLD_READOUT_BYPASS_EN
            check("t4_byp_count", 64'(count), 64'd0);
`else
            check("t4_stream_count", 64'(count), 64'd1);
`endif
        end
        cyc(1'b0, '0, 1'b1, 1'b0);
        check("t4_end_empty", 64'(empty), 64'd1);

        // Clear beats a same-cycle write and pop
        cyc(1'b1, 32'h61, 1'b0, 1'b0);
        cyc(1'b1, 32'h62, 1'b0, 1'b0);
        cyc(1'b1, 32'h63, 1'b1, 1'b1);
        idle_inputs();
        check("t5_clear_count", 64'(count), 64'd0);
        check("t5_clear_empty", 64'(empty), 64'd1);

        // Asynchronous reset between edges with three words and overflow set
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h50 + 32'(i), 1'b0, 1'b0);
        cyc(1'b1, 32'h54, 1'b0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0);
        idle_inputs();
        check("t6_pre_count", 64'(count), 64'd3);
        check("t6_pre_ovf", 64'(overflow), 64'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_count", 64'(count), 64'd0);
        check("t6_rst_full", 64'(full), 64'd0);
        check("t6_rst_ovf", 64'(overflow), 64'd0);
        check("t6_rst_data", 64'(output_data), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc(1'b0, '0, 1'b0, 1'b0);
        check("t6_post_empty", 64'(empty), 64'd1);

        // Write into an empty buffer with out_ready high
        write      = 1'b1;
        input_data = 32'h55;
        out_ready  = 1'b1;
        #1;
`ifdef HOLD_READOUT_BYPASS_EN
        check("t7_byp_valid", 64'(out_valid), 64'd1);
        check("t7_byp_data", 64'(output_data), 64'h55);
        check("t7_byp_count", 64'(count), 64'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        check("t7_byp_after_count", 64'(count), 64'd0);
        check("t7_byp_after_empty", 64'(empty), 64'd1);
`else
        check("t7_same_cycle_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        check("t7_next_valid", 64'(out_valid), 64'd1);
        check("t7_next_data", 64'(output_data), 64'h55);
        check("t7_next_count", 64'(count), 64'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
